// File: rtl/vis_frame_sequencer.sv
// Visibility datapath sequencer: tracks ping-pong IQ bank occupancy and sweeps
// read address / time slot over each full bank, then drains and releases it.
module vis_frame_sequencer #(
  parameter int COUNT = 15,
  parameter int ADDR  = 4,
  parameter int TRATE = 30,
  parameter int TBITS = 5,
  parameter int DRAIN = 4,
  parameter int DBITS = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             bank_rdy_i,
  output logic             bank_free_o,
  output logic             rd_en_o,
  output logic             rd_bank_o,
  output logic [ADDR-1:0]  rd_addr_o,
  output logic [TBITS-1:0] slot_o,
  output logic             cor_enable_o,
  output logic             cor_first_o,
  output logic             cor_last_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic [1:0]       full_o,
  output logic             overrun_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [ADDR-1:0]  ADDR_LAST  = ADDR'(COUNT - 1);
  localparam logic [TBITS-1:0] SLOT_LAST  = TBITS'(TRATE - 1);
  localparam logic [DBITS-1:0] DRAIN_LAST = DBITS'(DRAIN - 1);

  logic [1:0]       state_reg, state_next;
  logic [ADDR-1:0]  addr_reg, addr_next;
  logic [TBITS-1:0] slot_reg, slot_next;
  logic [DBITS-1:0] drain_reg, drain_next;
  logic             bank_reg, bank_next;
  logic [1:0]       full_reg, full_next;
  logic             overrun_reg, overrun_next;
  logic             cor_enable_reg, cor_first_reg, cor_last_reg;
  logic             reading, releasing, overrun_set;

  assign reading   = (state_reg == S_RUN);
  assign releasing = (state_reg == S_RELEASE);

  // Occupancy: a release and a completed bank in the same cycle cancel out.
  always_comb begin
    full_next = full_reg;
    case ({bank_rdy_i, releasing})
      2'b10:   full_next = (full_reg == 2'd2) ? 2'd2 : full_reg + 2'd1;
      2'b01:   full_next = full_reg - 2'd1;
      default: full_next = full_reg;
    endcase
  end

  assign overrun_set  = bank_rdy_i && !releasing && (full_reg == 2'd2);
  assign overrun_next = overrun_set ? 1'b1 : (clear_i ? 1'b0 : overrun_reg);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    slot_next  = slot_reg;
    drain_next = drain_reg;
    bank_next  = bank_reg;
    case (state_reg)
      S_IDLE: begin
        if ((full_reg != 2'd0) && enable_i) state_next = S_RUN;
      end
      S_RUN: begin
        if (addr_reg == ADDR_LAST) begin
          addr_next = '0;
          if (slot_reg == SLOT_LAST) begin
            slot_next  = '0;
            state_next = S_DRAIN;
          end else begin
            slot_next = slot_reg + TBITS'(1);
          end
        end else begin
          addr_next = addr_reg + ADDR'(1);
        end
      end
      S_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          drain_next = '0;
          state_next = S_RELEASE;
        end else begin
          drain_next = drain_reg + DBITS'(1);
        end
      end
      S_RELEASE: begin
        bank_next  = ~bank_reg;
        // Uses post-release occupancy so a queued bank starts without an IDLE cycle.
        state_next = ((full_next != 2'd0) && enable_i) ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      slot_reg       <= '0;
      drain_reg      <= '0;
      bank_reg       <= 1'b0;
      full_reg       <= 2'd0;
      overrun_reg    <= 1'b0;
      cor_enable_reg <= 1'b0;
      cor_first_reg  <= 1'b0;
      cor_last_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      slot_reg       <= slot_next;
      drain_reg      <= drain_next;
      bank_reg       <= bank_next;
      full_reg       <= full_next;
      overrun_reg    <= overrun_next;
      cor_enable_reg <= reading;
      cor_first_reg  <= reading && (addr_reg == '0);
      cor_last_reg   <= reading && (addr_reg == ADDR_LAST);
    end
  end

  assign bank_free_o  = releasing;
  assign rd_en_o      = reading;
  assign rd_bank_o    = bank_reg;
  assign rd_addr_o    = addr_reg;
  assign slot_o       = slot_reg;
  assign cor_enable_o = cor_enable_reg;
  assign cor_first_o  = cor_first_reg;
  assign cor_last_o   = cor_last_reg;
  assign frame_o      = reading || (state_reg == S_DRAIN);
  assign busy_o       = (state_reg != S_IDLE);
  assign full_o       = full_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_vis_frame_sequencer.sv
// Directed bench for vis_frame_sequencer with COUNT=3, TRATE=2, DRAIN=2.
module tb_vis_frame_sequencer;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       bank_rdy_i = 1'b0;
  logic       bank_free_o, rd_en_o, rd_bank_o;
  logic [1:0] rd_addr_o;
  logic [0:0] slot_o;
  logic       cor_enable_o, cor_first_o, cor_last_o, frame_o, busy_o, overrun_o;
  logic [1:0] full_o;

  int errors = 0;
  int checks = 0;
  int n, reads;

  int e_rd_en[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int e_addr[10]  = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0};
  int e_slot[10]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int e_cen[10]   = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int e_first[10] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  int e_last[10]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  int e_free[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int e_frame[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int e_busy[10]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int e_full[10]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int e_bank[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  vis_frame_sequencer #(
    .COUNT(3), .ADDR(2), .TRATE(2), .TBITS(1), .DRAIN(2), .DBITS(2)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .bank_rdy_i(bank_rdy_i), .bank_free_o(bank_free_o), .rd_en_o(rd_en_o),
    .rd_bank_o(rd_bank_o), .rd_addr_o(rd_addr_o), .slot_o(slot_o),
    .cor_enable_o(cor_enable_o), .cor_first_o(cor_first_o), .cor_last_o(cor_last_o),
    .frame_o(frame_o), .busy_o(busy_o), .full_o(full_o), .overrun_o(overrun_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; bank_rdy_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  // Advances until bank_free_o, counting elapsed cycles and sampled read cycles.
  task automatic wait_free(input string tag, output int cyc, output int rd);
    cyc = 0;
    rd  = 0;
    while (!bank_free_o && cyc < 60) begin
      if (rd_en_o) rd++;
      tick();
      cyc++;
    end
    chk({tag, "_free_seen"}, 32'(bank_free_o), 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_en", 32'(rd_en_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_bank", 32'(rd_bank_o), 0);
    chk("rst_frame", 32'(frame_o), 0);
    chk("rst_free", 32'(bank_free_o), 0);
    chk("rst_cor_en", 32'(cor_enable_o), 0);

    // 1. Single bank
    enable_i = 1'b1; bank_rdy_i = 1'b1;
    tick();
    bank_rdy_i = 1'b0;
    chk("s1_full_pre", 32'(full_o), 1);
    chk("s1_busy_pre", 32'(busy_o), 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("s1_rd_en_k%0d", k), 32'(rd_en_o), 32'(e_rd_en[k]));
      chk($sformatf("s1_addr_k%0d", k), 32'(rd_addr_o), 32'(e_addr[k]));
      chk($sformatf("s1_slot_k%0d", k), 32'(slot_o), 32'(e_slot[k]));
      chk($sformatf("s1_cor_en_k%0d", k), 32'(cor_enable_o), 32'(e_cen[k]));
      chk($sformatf("s1_first_k%0d", k), 32'(cor_first_o), 32'(e_first[k]));
      chk($sformatf("s1_last_k%0d", k), 32'(cor_last_o), 32'(e_last[k]));
      chk($sformatf("s1_free_k%0d", k), 32'(bank_free_o), 32'(e_free[k]));
      chk($sformatf("s1_frame_k%0d", k), 32'(frame_o), 32'(e_frame[k]));
      chk($sformatf("s1_busy_k%0d", k), 32'(busy_o), 32'(e_busy[k]));
      chk($sformatf("s1_full_k%0d", k), 32'(full_o), 32'(e_full[k]));
      chk($sformatf("s1_bank_k%0d", k), 32'(rd_bank_o), 32'(e_bank[k]));
      tick();
    end
    $display("s1 single bank done");

    // 2. Back-to-back banks
    do_reset();
    enable_i = 1'b1; bank_rdy_i = 1'b1;
    tick();
    bank_rdy_i = 1'b0;
    chk("s2_full_1", 32'(full_o), 1);
    tick();
    chk("s2_run0", 32'(rd_en_o), 1);
    tick();
    bank_rdy_i = 1'b1;
    tick();
    bank_rdy_i = 1'b0;
    chk("s2_full_2", 32'(full_o), 2);
    wait_free("s2a", n, reads);
    chk("s2a_cycles", 32'(n), 6);
    chk("s2a_full_at_free", 32'(full_o), 2);
    chk("s2a_bank", 32'(rd_bank_o), 0);
    chk("s2a_gap_rd_en", 32'(rd_en_o), 0);
    tick();
    chk("s2b_rd_en", 32'(rd_en_o), 1);
    chk("s2b_addr", 32'(rd_addr_o), 0);
    chk("s2b_bank", 32'(rd_bank_o), 1);
    chk("s2b_full", 32'(full_o), 1);
    wait_free("s2b", n, reads);
    chk("s2b_cycles", 32'(n), 8);
    chk("s2b_reads", 32'(reads), 6);
    tick();
    chk("s2_full_end", 32'(full_o), 0);
    chk("s2_busy_end", 32'(busy_o), 0);
    $display("s2 back-to-back done");

    // 3. Overrun
    do_reset();
    bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    chk("s3_full_1", 32'(full_o), 1);
    bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    chk("s3_full_2", 32'(full_o), 2);
    chk("s3_ov_0", 32'(overrun_o), 0);
    bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    chk("s3_full_sat", 32'(full_o), 2);
    chk("s3_ov_1", 32'(overrun_o), 1);
    chk("s3_idle", 32'(busy_o), 0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("s3_ov_clr", 32'(overrun_o), 0);
    bank_rdy_i = 1'b1; clear_i = 1'b1; tick(); bank_rdy_i = 1'b0; clear_i = 1'b0;
    chk("s3_ov_set_wins", 32'(overrun_o), 1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("s3_ov_clr2", 32'(overrun_o), 0);
    enable_i = 1'b1; tick();
    chk("s3a_rd_en", 32'(rd_en_o), 1);
    chk("s3a_bank", 32'(rd_bank_o), 0);
    wait_free("s3a", n, reads);
    chk("s3a_cycles", 32'(n), 8);
    tick();
    chk("s3b_rd_en", 32'(rd_en_o), 1);
    chk("s3b_bank", 32'(rd_bank_o), 1);
    chk("s3b_full", 32'(full_o), 1);
    wait_free("s3b", n, reads);
    chk("s3b_cycles", 32'(n), 8);
    tick();
    chk("s3_busy_end", 32'(busy_o), 0);
    chk("s3_full_end", 32'(full_o), 0);
    chk("s3_bank_end", 32'(rd_bank_o), 0);
    $display("s3 overrun done");

    // 4. Ready coinciding with release at full=2
    do_reset();
    enable_i = 1'b1; bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    tick();
    bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    chk("s4_full_2", 32'(full_o), 2);
    wait_free("s4", n, reads);
    chk("s4_cycles", 32'(n), 7);
    bank_rdy_i = 1'b1; tick(); bank_rdy_i = 1'b0;
    chk("s4_full_keep", 32'(full_o), 2);
    chk("s4_ov_keep", 32'(overrun_o), 0);
    chk("s4_rd_en", 32'(rd_en_o), 1);
    chk("s4_bank", 32'(rd_bank_o), 1);
    $display("s4 simultaneous done");

    // 5. Enable dropped mid-frame
    do_reset();
    bank_rdy_i = 1'b1; tick(); tick(); bank_rdy_i = 1'b0;
    chk("s5_full_2", 32'(full_o), 2);
    enable_i = 1'b1; tick(); tick(); tick();
    chk("s5_addr_k2", 32'(rd_addr_o), 2);
    enable_i = 1'b0;
    wait_free("s5", n, reads);
    chk("s5_cycles", 32'(n), 6);
    chk("s5_reads", 32'(reads), 4);
    chk("s5_full_at_free", 32'(full_o), 2);
    tick();
    chk("s5_idle", 32'(busy_o), 0);
    chk("s5_full_1", 32'(full_o), 1);
    chk("s5_bank", 32'(rd_bank_o), 1);
    tick(); tick();
    chk("s5_hold_rd_en", 32'(rd_en_o), 0);
    enable_i = 1'b1; tick();
    chk("s5_resume", 32'(rd_en_o), 1);
    chk("s5_resume_bank", 32'(rd_bank_o), 1);
    $display("s5 enable drop done");

    // 6. Asynchronous reset during the second sweep
    do_reset();
    bank_rdy_i = 1'b1; tick(); tick(); bank_rdy_i = 1'b0;
    enable_i = 1'b1; tick();
    wait_free("s6", n, reads);
    tick(); tick(); tick();
    chk("s6_pre_rd_en", 32'(rd_en_o), 1);
    chk("s6_pre_bank", 32'(rd_bank_o), 1);
    #2 reset_i = 1'b1;
    #1;
    chk("s6_rd_en", 32'(rd_en_o), 0);
    chk("s6_bank", 32'(rd_bank_o), 0);
    chk("s6_full", 32'(full_o), 0);
    chk("s6_busy", 32'(busy_o), 0);
    chk("s6_frame", 32'(frame_o), 0);
    chk("s6_addr", 32'(rd_addr_o), 0);
    chk("s6_cor_en", 32'(cor_enable_o), 0);
    chk("s6_free", 32'(bank_free_o), 0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("s6_post_free", 32'(bank_free_o), 0);
    chk("s6_post_busy", 32'(busy_o), 0);
    $display("s6 async reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vis_frame_sequencer.md
Name: vis_frame_sequencer

Overview:
- Sequences the correlator array's visibility datapath.
- Tracks the two ping-pong IQ-buffer banks filled by the signal writer.
- When a bank is full, generates the read-bank/read-address/time-slot sweep into the buffer SRAM, plus the pipelined enable/first/last strobes to the correlator cores and accumulator.
- After the pipeline drains, releases the bank back to the writer.

Parameters:
- COUNT, 15, samples per bank; also the number of partial-sum terms per time slot.
- ADDR, 4, width of the read address; must satisfy 2**ADDR >= COUNT.
- TRATE, 30, time-multiplexing rate; number of slots swept per bank.
- TBITS, 5, width of the slot index; ceil(log2(TRATE)).
- DRAIN, 4, flush cycles after the final read, covering the core chain and accumulator latency; minimum 1.
- DBITS, 3, width of the drain counter; must hold DRAIN.

Ports:
- clock_i  in  1  vis_clock domain clock.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  allows a new bank sweep to start.
- clear_i  in  1  synchronous clear of overrun_o.
- bank_rdy_i  in  1  one-cycle pulse: the writer completed a bank (already synchronised to clock_i).
- bank_free_o  out  1  one-cycle pulse: the current read bank is released to the writer.
- rd_en_o  out  1  SRAM read enable.
- rd_bank_o  out  1  bank being read.
- rd_addr_o  out  ADDR  SRAM word address.
- slot_o  out  TBITS  current time slot, aligned with rd_addr_o.
- cor_enable_o  out  1  correlator enable; rd_en_o delayed 1 cycle.
- cor_first_o  out  1  first term of a slot; aligned with cor_enable_o.
- cor_last_o  out  1  last term of a slot; aligned with cor_enable_o.
- frame_o  out  1  high from the first read of a bank through the end of DRAIN.
- busy_o  out  1  state != IDLE.
- full_o  out  2  number of full banks not yet released (0..2).
- overrun_o  out  1  sticky: writer completed a bank while both banks were full.

Behaviour:
Reset: all outputs 0, state IDLE, rd_bank_o=0, full count=0, overrun_o=0, all counters 0.

Occupancy:
- bank_rdy_i alone increments the full count.
- bank_free_o alone decrements it.
- bank_rdy_i and bank_free_o in the same cycle leave it unchanged.
- bank_rdy_i when count=2 with no simultaneous free sets overrun_o; the count stays 2.
- clear_i clears overrun_o. If clear_i and an overrun event coincide, the set wins.

FSM states: IDLE, RUN, DRAIN, RELEASE.
- IDLE -> RUN when full count > 0 and enable_i. The full count is the registered value; a bank_rdy_i in the same cycle is seen one cycle later.
- RUN:
  - rd_en_o=1 every cycle.
  - rd_addr_o steps 0..COUNT-1. On wrap it returns to 0 and slot_o increments.
  - After addr COUNT-1 of slot TRATE-1, go to DRAIN.
  - RUN lasts exactly COUNT*TRATE cycles.
- DRAIN:
  - rd_en_o=0, rd_addr_o=0, slot_o=0.
  - Lasts DRAIN cycles, then go to RELEASE.
- RELEASE (1 cycle):
  - bank_free_o=1 and rd_bank_o toggles; the toggle is visible the next cycle.
  - Next state is RUN if (full count after the decrement) > 0 and enable_i; otherwise IDLE.
  - Back-to-back banks therefore have exactly DRAIN+1 idle read cycles between them.

Strobes:
- cor_enable_o(t) = rd_en_o(t-1).
- cor_first_o(t) = rd_en_o and rd_addr_o==0, both at t-1.
- cor_last_o(t) = rd_en_o and rd_addr_o==COUNT-1, both at t-1.

frame_o: asserted the cycle RUN is entered; deasserted the cycle RELEASE is entered.

enable_i low mid-frame: the current bank completes normally; only new starts are inhibited.

Arithmetic: counters compare against COUNT-1, TRATE-1 and DRAIN-1, never against 2**width, so non-power-of-two values wrap correctly.

Reset mid-operation: immediate return to the reset state. Pending banks are discarded and rd_bank_o restarts at 0; the writer is reset alongside.

Test Plan:
Bench parameters for all scenarios: COUNT=3, TRATE=2, DRAIN=2, ADDR=2, TBITS=1.
1. Single bank:
   - Stimulus: pulse bank_rdy_i with enable_i=1.
   - Response: rd_en_o high for 6 cycles with rd_addr_o 0,1,2,0,1,2 and slot_o 0,0,0,1,1,1.
   - cor_first_o at relative cycles 1 and 4; cor_last_o at 3 and 6.
   - bank_free_o at cycle 8 (2 DRAIN cycles after the last read); rd_bank_o is then 1, full_o returns 0.
2. Back-to-back banks:
   - Stimulus: two bank_rdy_i pulses 3 cycles apart.
   - Response: second sweep starts the cycle after bank_free_o, with rd_bank_o=1 and a 3-cycle read gap.
   - full_o sequence: 1, 2, 1, 0.
3. Overrun:
   - Stimulus: three bank_rdy_i pulses while enable_i=0.
   - Response: full_o=2, overrun_o=1 after the third pulse.
   - Then clear_i -> overrun_o=0.
   - Then enable_i=1 -> two sweeps, banks 0 then 1.
4. Simultaneous events:
   - Stimulus: bank_rdy_i in the same cycle as bank_free_o with full_o=2.
   - Response: full_o stays 2, overrun_o stays 0.
5. Enable drop mid-frame:
   - Stimulus: enable_i=0 at RUN cycle 2 with full_o=2.
   - Response: current sweep completes all 6 reads and bank_free_o; then IDLE with full_o=1, and resumes 1 cycle after enable_i=1.
6. Async reset mid-RUN:
   - Stimulus: reset_i asserted between clock edges.
   - Response: all outputs 0 immediately, full_o=0, rd_bank_o=0; no bank_free_o pulse.
